// File: rtl/decoder_nx_seq_pkg.sv
// Shared definitions for the N-to-2^N sequencing decoder.
// The mode encoding is used by both the RTL and the testbench.
package decoder_pkg;

  typedef enum logic [1:0] {
    MODE_DIRECT    = 2'b00,
    MODE_SCAN_UP   = 2'b01,
    MODE_SCAN_DOWN = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_e;

endpackage

// File: rtl/decoder_nx_seq_if.sv
// Control/select bundle for decoder_nx_seq.
//   en, mode, sel_valid, sel             : driven by the controller (master)
//   sel_ready, dec_out, cur_sel,
//   out_valid, wrap                      : driven by the decoder (slave)
interface decoder_nx_seq_if #(
  parameter int unsigned SEL_W = 3
);
  localparam int unsigned OUT_W = 2 ** SEL_W;

  logic             en;
  logic [1:0]       mode;
  logic             sel_valid;
  logic [SEL_W-1:0] sel;
  logic             sel_ready;
  logic [OUT_W-1:0] dec_out;
  logic [SEL_W-1:0] cur_sel;
  logic             out_valid;
  logic             wrap;

  modport master (
    output en, mode, sel_valid, sel,
    input  sel_ready, dec_out, cur_sel, out_valid, wrap
  );

  modport slave (
    input  en, mode, sel_valid, sel,
    output sel_ready, dec_out, cur_sel, out_valid, wrap
  );

endinterface

// File: rtl/decoder_nx_seq_prescaler.sv
// Scan-step prescaler: counts 0..SCAN_DIV-1 while cnt_en is high and
// produces a terminal-count pulse (tc) on the cycle whose edge takes a step.
//   clk, rst_n : clock, async active-low reset
//   clr        : treat the count as zero this cycle (first cycle of a mode)
//   cnt_en     : advance the count this cycle
//   tc         : combinational terminal-count pulse
module decoder_prescaler #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic cnt_en,
  output logic tc
);
  localparam int unsigned    PW     = $clog2(SCAN_DIV) + 1;
  localparam logic [PW-1:0]  TC_VAL = PW'(SCAN_DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;
  logic [PW-1:0] eff;

  // The clear takes effect within the same cycle, so the first cycle of a
  // new mode already counts as step 0 and a full period is SCAN_DIV edges.
  always_comb begin
    eff   = clr ? '0 : cnt_q;
    tc    = cnt_en && (eff == TC_VAL);
    cnt_d = cnt_q;
    if (cnt_en)   cnt_d = tc ? '0 : eff + PW'(1);
    else if (clr) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/decoder_nx_seq.sv
// Registered N-to-2^N one-hot (or one-cold) decoder with enable,
// valid/ready load handshake and prescaled up/down scan modes.
//   clk   : rising-edge clock
//   rst_n : async active-low reset
//   bus   : decoder_nx_seq_if slave (en, mode, sel_valid, sel in;
//           sel_ready, dec_out, cur_sel, out_valid, wrap out)
module decoder_nx_seq
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned SCAN_DIV   = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  decoder_nx_seq_if.slave   bus
);
  localparam int unsigned      OUT_W = 2 ** SEL_W;
  localparam logic [OUT_W-1:0] POL   = ACTIVE_LOW ? '1 : '0;
  localparam logic [SEL_W-1:0] MAX_SEL = '1;

  mode_e            mode_q, mode_d, mode_in;
  logic [SEL_W-1:0] cur_sel_q, sel_d;
  logic             valid_q, valid_d;
  logic             loaded_q, loaded_d;
  logic             wrap_q, wrap_d;
  logic [OUT_W-1:0] dec_q, dec_d;
  logic             mode_chg, presc_clr, presc_en, tc;

  decoder_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (presc_clr),
    .cnt_en (presc_en),
    .tc     (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_DIRECT;
      cur_sel_q <= '0;
      valid_q   <= 1'b0;
      loaded_q  <= 1'b0;
      wrap_q    <= 1'b0;
      dec_q     <= POL;
    end else begin
      mode_q    <= mode_d;
      cur_sel_q <= sel_d;
      valid_q   <= valid_d;
      loaded_q  <= loaded_d;
      wrap_q    <= wrap_d;
      dec_q     <= dec_d;
    end
  end

  // mode_q remembers the last mode seen while enabled, so a mode change made
  // during en=0 is still treated as a change once the block is re-enabled.
  // loaded_q records that a selection exists, letting HOLD re-assert
  // out_valid after an en=0 period cleared it.
  always_comb begin
    mode_in   = mode_e'(bus.mode);
    mode_chg  = (mode_in != mode_q);
    mode_d    = bus.en ? mode_in : mode_q;
    presc_clr = bus.en && (mode_chg || mode_in == MODE_DIRECT);
    presc_en  = bus.en && (mode_in == MODE_SCAN_UP || mode_in == MODE_SCAN_DOWN);
    sel_d     = cur_sel_q;
    valid_d   = valid_q;
    loaded_d  = loaded_q;
    wrap_d    = 1'b0;

    if (!bus.en) begin
      valid_d = 1'b0;
    end else begin
      unique case (mode_in)
        MODE_DIRECT: begin
          if (bus.sel_valid) begin
            sel_d    = bus.sel;
            valid_d  = 1'b1;
            loaded_d = 1'b1;
          end
        end
        MODE_SCAN_UP: begin
          if (tc) begin
            sel_d    = cur_sel_q + SEL_W'(1);
            valid_d  = 1'b1;
            loaded_d = 1'b1;
            wrap_d   = (cur_sel_q == MAX_SEL);
          end
        end
        MODE_SCAN_DOWN: begin
          if (tc) begin
            sel_d    = cur_sel_q - SEL_W'(1);
            valid_d  = 1'b1;
            loaded_d = 1'b1;
            wrap_d   = (cur_sel_q == '0);
          end
        end
        MODE_HOLD: begin
          valid_d = loaded_q;
        end
        default: ;
      endcase
    end

    dec_d = (valid_d ? (OUT_W'(1) << sel_d) : '0) ^ POL;
  end

  assign bus.sel_ready = bus.en && (mode_in == MODE_DIRECT);
  assign bus.dec_out   = dec_q;
  assign bus.cur_sel   = cur_sel_q;
  assign bus.out_valid = valid_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_decoder_nx_seq.sv
// Directed self-checking bench for decoder_nx_seq (SEL_W=3, SCAN_DIV=4),
// with a second ACTIVE_LOW=1 instance for polarity checks.
module tb_decoder_nx_seq;
  import decoder_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  logic [12:0] obs;
  logic [12:0] exp_v;

  decoder_nx_seq_if #(.SEL_W(3)) bus0 ();
  decoder_nx_seq_if #(.SEL_W(3)) bus1 ();

  decoder_nx_seq #(.SEL_W(3), .SCAN_DIV(4), .ACTIVE_LOW(1'b0)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  decoder_nx_seq #(.SEL_W(3), .SCAN_DIV(4), .ACTIVE_LOW(1'b1)) u_dut_al (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus0.en = 1'b1; bus0.mode = MODE_DIRECT; bus0.sel = 3'd5; bus0.sel_valid = 1'b1;
    bus1.en = 1'b1; bus1.mode = MODE_DIRECT; bus1.sel = 3'd5; bus1.sel_valid = 1'b1;
    tick();
    bus0.sel_valid = 1'b0; bus1.sel_valid = 1'b0;
    obs = {bus0.dec_out, bus0.cur_sel, bus0.out_valid, bus0.wrap};
    exp_v = {8'h20, 3'd5, 1'b1, 1'b0};
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_preload: got %h expected %h", obs, exp_v); end
    #2;
    rst_n = 1'b0;
    #1;
    obs = {bus0.dec_out, bus0.cur_sel, bus0.out_valid, bus0.wrap};
    exp_v = {8'h00, 3'd0, 1'b0, 1'b0};
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_async: got %h expected %h", obs, exp_v); end
    n_vec++;
    if (bus1.dec_out !== 8'hFF) begin n_err++; $display("FAIL reset_active_low: got %h expected ff", bus1.dec_out); end
    tick();
    rst_n = 1'b1;
    tick();
    obs = {bus0.dec_out, bus0.cur_sel, bus0.out_valid, bus0.wrap};
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_release: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_direct_sweep();
    bus0.en = 1'b1; bus0.mode = MODE_DIRECT;
    for (int i = 0; i < 8; i++) begin
      bus0.sel = 3'(i); bus0.sel_valid = 1'b1;
      #1;
      n_vec++;
      if (bus0.sel_ready !== 1'b1) begin n_err++; $display("FAIL direct_ready %0d: got %b expected 1", i, bus0.sel_ready); end
      tick();
      obs = {bus0.dec_out, bus0.cur_sel, bus0.out_valid, bus0.wrap};
      exp_v = {8'h01 << i, 3'(i), 1'b1, 1'b0};
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL direct_sel %0d: got %h expected %h", i, obs, exp_v); end
    end
    bus0.sel = 3'd2; bus0.sel_valid = 1'b0;
    tick();
    obs = {bus0.dec_out, bus0.cur_sel, bus0.out_valid, bus0.wrap};
    exp_v = {8'h80, 3'd7, 1'b1, 1'b0};
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL direct_hold_no_load: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_scan_up();
    bus0.mode = MODE_DIRECT; bus0.sel = 3'd6; bus0.sel_valid = 1'b1;
    tick();
    bus0.sel_valid = 1'b0; bus0.mode = MODE_SCAN_UP;
    #1;
    n_vec++;
    if (bus0.sel_ready !== 1'b0) begin n_err++; $display("FAIL scan_up_ready: got %b expected 0", bus0.sel_ready); end
    for (int i = 1; i <= 9; i++) begin
      tick();
      obs = {bus0.dec_out, bus0.cur_sel, bus0.out_valid, bus0.wrap};
      if (i < 4)       exp_v = {8'h40, 3'd6, 1'b1, 1'b0};
      else if (i < 8)  exp_v = {8'h80, 3'd7, 1'b1, 1'b0};
      else if (i == 8) exp_v = {8'h01, 3'd0, 1'b1, 1'b1};
      else             exp_v = {8'h01, 3'd0, 1'b1, 1'b0};
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL scan_up clk %0d: got %h expected %h", i, obs, exp_v); end
    end
  endtask

  task automatic test_scan_down();
    bus0.mode = MODE_DIRECT; bus0.sel = 3'd0; bus0.sel_valid = 1'b1;
    tick();
    bus0.mode = MODE_SCAN_DOWN; bus0.sel = 3'd3; bus0.sel_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      obs = {bus0.dec_out, bus0.cur_sel, bus0.out_valid, bus0.wrap};
      if (i < 4)       exp_v = {8'h01, 3'd0, 1'b1, 1'b0};
      else if (i == 4) exp_v = {8'h80, 3'd7, 1'b1, 1'b1};
      else             exp_v = {8'h80, 3'd7, 1'b1, 1'b0};
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL scan_down clk %0d: got %h expected %h", i, obs, exp_v); end
    end
    bus0.sel_valid = 1'b0;
  endtask

  task automatic test_enable();
    bus0.mode = MODE_DIRECT; bus0.sel = 3'd2; bus0.sel_valid = 1'b1;
    tick();
    bus0.sel_valid = 1'b0; bus0.mode = MODE_SCAN_UP;
    repeat (4) tick();
    obs = {bus0.dec_out, bus0.cur_sel, bus0.out_valid, bus0.wrap};
    exp_v = {8'h08, 3'd3, 1'b1, 1'b0};
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL enable_prestep: got %h expected %h", obs, exp_v); end
    bus0.en = 1'b0;
    #1;
    n_vec++;
    if (bus0.sel_ready !== 1'b0) begin n_err++; $display("FAIL enable_ready: got %b expected 0", bus0.sel_ready); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      obs = {bus0.dec_out, bus0.cur_sel, bus0.out_valid, bus0.wrap};
      exp_v = {8'h00, 3'd3, 1'b0, 1'b0};
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL enable_off clk %0d: got %h expected %h", i, obs, exp_v); end
    end
    bus0.en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      obs = {bus0.dec_out, bus0.cur_sel, bus0.out_valid, bus0.wrap};
      exp_v = (i < 4) ? {8'h00, 3'd3, 1'b0, 1'b0} : {8'h10, 3'd4, 1'b1, 1'b0};
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL enable_resume clk %0d: got %h expected %h", i, obs, exp_v); end
    end
  endtask

  task automatic test_hold();
    bus0.en = 1'b0;
    tick();
    obs = {bus0.dec_out, bus0.cur_sel, bus0.out_valid, bus0.wrap};
    exp_v = {8'h00, 3'd4, 1'b0, 1'b0};
    n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL hold_disabled: got %h expected %h", obs, exp_v); end
    bus0.en = 1'b1; bus0.mode = MODE_HOLD;
    for (int i = 1; i <= 5; i++) begin
      tick();
      obs = {bus0.dec_out, bus0.cur_sel, bus0.out_valid, bus0.wrap};
      exp_v = {8'h10, 3'd4, 1'b1, 1'b0};
      n_vec++;
      if (obs !== exp_v) begin n_err++; $display("FAIL hold clk %0d: got %h expected %h", i, obs, exp_v); end
    end
  endtask

  task automatic test_active_low();
    bus1.en = 1'b1; bus1.mode = MODE_DIRECT; bus1.sel = 3'd5; bus1.sel_valid = 1'b1;
    tick();
    bus1.sel_valid = 1'b0;
    n_vec++;
    if (bus1.dec_out !== 8'hDF) begin n_err++; $display("FAIL active_low_sel5: got %h expected df", bus1.dec_out); end
    bus1.sel = 3'd0; bus1.sel_valid = 1'b1;
    tick();
    bus1.sel_valid = 1'b0;
    n_vec++;
    if (bus1.dec_out !== 8'hFE) begin n_err++; $display("FAIL active_low_sel0: got %h expected fe", bus1.dec_out); end
    bus1.en = 1'b0;
    tick();
    n_vec++;
    if (bus1.dec_out !== 8'hFF) begin n_err++; $display("FAIL active_low_disabled: got %h expected ff", bus1.dec_out); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus0.en = 1'b0; bus0.mode = MODE_DIRECT; bus0.sel_valid = 1'b0; bus0.sel = '0;
    bus1.en = 1'b0; bus1.mode = MODE_DIRECT; bus1.sel_valid = 1'b0; bus1.sel = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_direct_sweep();
    test_scan_up();
    test_scan_down();
    test_enable();
    test_hold();
    test_active_low();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
